// File: rtl/sd_emmc_rx_deser_if.sv
// sd_emmc_rx_deser_if -- handshake/data bundle for the eMMC/SD receive deserialiser.
//   master : pad/host side, drives lane samples, start/abort and the block configuration
//   slave  : deserialiser, returns assembled words, completion strobe and error flags
interface sd_emmc_rx_deser_if #(
  parameter int LANES = 8,
  parameter int OUT_W = 32,
  parameter int LEN_W = 12,
  parameter int TO_W  = 16
);
  logic [LANES-1:0] rx_q1;
  logic [LANES-1:0] rx_q2;
  logic             start;
  logic             abort;
  logic             ddr_en;
  logic [1:0]       bus_width;
  logic [LEN_W-1:0] blk_len;
  logic [TO_W-1:0]  timeout;
  logic [OUT_W-1:0] data_out;
  logic             data_valid;
  logic             done;
  logic             end_err;
  logic             to_err;
  logic             busy;

  modport master (
    output rx_q1, rx_q2, start, abort, ddr_en, bus_width, blk_len, timeout,
    input  data_out, data_valid, done, end_err, to_err, busy
  );

  modport slave (
    input  rx_q1, rx_q2, start, abort, ddr_en, bus_width, blk_len, timeout,
    output data_out, data_valid, done, end_err, to_err, busy
  );
endinterface

// File: rtl/sd_emmc_rx_deser.sv
// sd_emmc_rx_deser -- receive deserialiser for eMMC/SD data lines.
// Waits for the start bit, packs the block MSB-first into OUT_W-bit words
// (SDR or DDR, bus width 1/4/8), skips the 16-cycle CRC field and checks the end bit.
//   clock, reset : receive clock, synchronous active-high reset
//   bus (slave)  : rx_q1/rx_q2 rising/falling lane samples, start/abort control,
//                  ddr_en/bus_width/blk_len latched on start, live timeout;
//                  data_out/data_valid word stream, done/end_err/to_err status, busy
module sd_emmc_rx_deser #(
  parameter int LANES = 8,
  parameter int OUT_W = 32,
  parameter int LEN_W = 12,
  parameter int TO_W  = 16
) (
  input logic               clock,
  input logic               reset,
  sd_emmc_rx_deser_if.slave bus
);
  localparam int BC_W = LEN_W + 3;          // holds blk_len*8 without wrapping
  localparam int WC_W = $clog2(OUT_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_CRC, S_END} state_t;

  state_t           state;
  logic             ddr_q;
  logic [1:0]       wsel_q;                 // 0: 1 lane, 1: 4 lanes, 2: 8 lanes
  logic [LEN_W-1:0] len_q;
  logic [OUT_W-1:0] sh;
  logic [WC_W-1:0]  wcnt;
  logic [BC_W-1:0]  bit_cnt;
  logic [3:0]       crc_cnt;
  logic [TO_W-1:0]  wait_cnt;
  logic [OUT_W-1:0] data_out_q;
  logic             data_valid_q, done_q, end_err_q, to_err_q;

  logic [7:0]       q1p, q2p, mask;
  logic [1:0]       wsel_in;
  logic [15:0]      beat;
  logic [4:0]       bpc;
  logic [OUT_W-1:0] sh_nxt;
  logic [WC_W-1:0]  word_nxt;
  logic [BC_W-1:0]  bit_nxt;

  // Zero-pad lanes to 8 so the beat mux is lane-count independent; padded
  // bits are never selected because the width is clamped to LANES.
  always_comb begin
    q1p = '0;
    q2p = '0;
    q1p[LANES-1:0] = bus.rx_q1;
    q2p[LANES-1:0] = bus.rx_q2;
  end

  always_comb begin
    wsel_in = 2'd0;
    if (bus.bus_width == 2'd2 && LANES >= 8)
      wsel_in = 2'd2;
    else if ((bus.bus_width == 2'd1 || bus.bus_width == 2'd2) && LANES >= 4)
      wsel_in = 2'd1;
  end

  always_comb begin
    case (wsel_q)
      2'd2:    mask = 8'hFF;
      2'd1:    mask = 8'h0F;
      default: mask = 8'h01;
    endcase
  end

  // Beat bits right-aligned, highest lane first; in DDR the rising half precedes the falling half.
  always_comb begin
    beat = '0;
    bpc  = 5'd1;
    case ({ddr_q, wsel_q})
      3'b0_01: begin beat = {12'h000, q1p[3:0]};         bpc = 5'd4;  end
      3'b0_10: begin beat = {8'h00, q1p};                bpc = 5'd8;  end
      3'b1_00: begin beat = {14'h0000, q1p[0], q2p[0]};  bpc = 5'd2;  end
      3'b1_01: begin beat = {8'h00, q1p[3:0], q2p[3:0]}; bpc = 5'd8;  end
      3'b1_10: begin beat = {q1p, q2p};                  bpc = 5'd16; end
      default: begin beat = {15'h0000, q1p[0]};          bpc = 5'd1;  end
    endcase
  end

  assign sh_nxt   = (sh << bpc) | OUT_W'(beat);
  assign word_nxt = wcnt + WC_W'(bpc);
  assign bit_nxt  = bit_cnt + BC_W'(bpc);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      ddr_q        <= 1'b0;
      wsel_q       <= 2'd0;
      len_q        <= '0;
      sh           <= '0;
      wcnt         <= '0;
      bit_cnt      <= '0;
      crc_cnt      <= '0;
      wait_cnt     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      end_err_q    <= 1'b0;
      to_err_q     <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      if (bus.abort) begin
        state <= S_IDLE;                    // partial word dropped, flags untouched
      end else begin
        case (state)
          S_IDLE: if (bus.start) begin
            ddr_q     <= bus.ddr_en;
            wsel_q    <= wsel_in;
            len_q     <= bus.blk_len;
            end_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            wait_cnt  <= '0;
            state     <= S_WAIT;
          end
          S_WAIT: begin
            if ((q1p & mask) == 8'h00) begin
              sh      <= '0;
              wcnt    <= '0;
              bit_cnt <= '0;
              state   <= S_DATA;
            end else if (bus.timeout != '0 && (wait_cnt + TO_W'(1)) == bus.timeout) begin
              done_q   <= 1'b1;
              to_err_q <= 1'b1;
              state    <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + TO_W'(1);
            end
          end
          S_DATA: begin
            sh      <= sh_nxt;
            bit_cnt <= bit_nxt;
            // bpc always divides OUT_W, so a word completes exactly on this compare
            if (word_nxt == WC_W'(OUT_W)) begin
              wcnt         <= '0;
              data_out_q   <= sh_nxt;
              data_valid_q <= 1'b1;
            end else begin
              wcnt <= word_nxt;
            end
            if (bit_nxt == {len_q, 3'b000}) begin
              crc_cnt <= '0;
              state   <= S_CRC;
            end
          end
          S_CRC: begin
            crc_cnt <= crc_cnt + 4'd1;
            if (crc_cnt == 4'd15) state <= S_END;
          end
          S_END: begin
            end_err_q <= ((q1p & mask) != mask);
            done_q    <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.done       = done_q;
  assign bus.end_err    = end_err_q;
  assign bus.to_err     = to_err_q;
  assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_sd_emmc_rx_deser.sv
// tb_sd_emmc_rx_deser -- directed self-checking bench for sd_emmc_rx_deser.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Event stamps use the index of the rising edge that produced them.
module tb_sd_emmc_rx_deser;
  localparam int LANES = 8, OUT_W = 32, LEN_W = 12, TO_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sd_emmc_rx_deser_if #(.LANES(LANES), .OUT_W(OUT_W), .LEN_W(LEN_W), .TO_W(TO_W)) bus ();

  sd_emmc_rx_deser #(.LANES(LANES), .OUT_W(OUT_W), .LEN_W(LEN_W), .TO_W(TO_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] got_w[$];
  int          got_c[$];
  int          done_c[$];
  logic        done_ee, done_te;

  always @(negedge clock) begin
    if (bus.data_valid === 1'b1) begin got_w.push_back(bus.data_out); got_c.push_back(cyc); end
    if (bus.done === 1'b1) begin done_c.push_back(cyc); done_ee = bus.end_err; done_te = bus.to_err; end
  end

  task automatic clear_mon();
    got_w.delete(); got_c.delete(); done_c.delete();
  endtask

  task automatic beat(input logic [7:0] q1, input logic [7:0] q2);
    bus.rx_q1 = q1; bus.rx_q2 = q2;
    @(negedge clock);
  endtask

  task automatic arm(input logic ddr, input logic [1:0] bw, input logic [11:0] len,
                     input logic [15:0] to, output int acc);
    bus.ddr_en = ddr; bus.bus_width = bw; bus.blk_len = len; bus.timeout = to; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    acc = cyc;
  endtask

  // one idle cycle in WAIT_START, then the start bit; s = rising edge sampling the start bit
  task automatic start_bit(output int s);
    beat(8'hFF, 8'hFF);
    s = cyc + 1;
    beat(8'h00, 8'hA5);
  endtask

  // CRC lanes driven low so a short CRC count would see a bad end bit
  task automatic crc_end(input logic [7:0] endv);
    repeat (16) beat(8'h00, 8'h3C);
    beat(endv, 8'h00);
    repeat (3) beat(8'hFF, 8'hFF);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL rst_data_out got=%h exp=0", bus.data_out); end
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL rst_data_valid got=%b exp=0", bus.data_valid); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    total++; if (bus.end_err !== 1'b0) begin bad++; $display("FAIL rst_end_err got=%b exp=0", bus.end_err); end
    total++; if (bus.to_err !== 1'b0) begin bad++; $display("FAIL rst_to_err got=%b exp=0", bus.to_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_ddr8();
    int a, s;
    clear_mon();
    arm(1'b1, 2'd2, 12'd8, 16'd0, a);
    start_bit(s);
    beat(8'h01, 8'h02); beat(8'h03, 8'h04); beat(8'h05, 8'h06); beat(8'h07, 8'h08);
    crc_end(8'hFF);
    total++; if (got_w.size() !== 2) begin bad++; $display("FAIL ddr8_nwords got=%0d exp=2", got_w.size()); end
    if (got_w.size() >= 2) begin
      total++; if (got_w[0] !== 32'h01020304) begin bad++; $display("FAIL ddr8_w0 got=%h exp=01020304", got_w[0]); end
      total++; if (got_w[1] !== 32'h05060708) begin bad++; $display("FAIL ddr8_w1 got=%h exp=05060708", got_w[1]); end
      total++; if (got_c[0] !== s + 2) begin bad++; $display("FAIL ddr8_t0 got=%0d exp=%0d", got_c[0], s + 2); end
      total++; if (got_c[1] !== s + 4) begin bad++; $display("FAIL ddr8_t1 got=%0d exp=%0d", got_c[1], s + 4); end
    end
    total++; if (done_c.size() !== 1) begin bad++; $display("FAIL ddr8_ndone got=%0d exp=1", done_c.size()); end
    if (done_c.size() >= 1) begin
      total++; if (done_c[0] !== s + 21) begin bad++; $display("FAIL ddr8_tdone got=%0d exp=%0d", done_c[0], s + 21); end
    end
    total++; if (done_ee !== 1'b0) begin bad++; $display("FAIL ddr8_end_err got=%b exp=0", done_ee); end
    total++; if (done_te !== 1'b0) begin bad++; $display("FAIL ddr8_to_err got=%b exp=0", done_te); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ddr8_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_sdr4();
    int a, s;
    clear_mon();
    arm(1'b0, 2'd1, 12'd4, 16'd0, a);
    start_bit(s);
    // upper (inactive) lanes carry junk that must be ignored
    beat(8'h5A, 8'h11); beat(8'hFB, 8'h22); beat(8'h0C, 8'h33); beat(8'h9D, 8'h44);
    beat(8'hE1, 8'h55); beat(8'h02, 8'h66); beat(8'h73, 8'h77); beat(8'hC4, 8'h88);
    crc_end(8'h0F);
    total++; if (got_w.size() !== 1) begin bad++; $display("FAIL sdr4_nwords got=%0d exp=1", got_w.size()); end
    if (got_w.size() >= 1) begin
      total++; if (got_w[0] !== 32'hABCD1234) begin bad++; $display("FAIL sdr4_w0 got=%h exp=abcd1234", got_w[0]); end
      total++; if (got_c[0] !== s + 8) begin bad++; $display("FAIL sdr4_t0 got=%0d exp=%0d", got_c[0], s + 8); end
    end
    total++; if (done_c.size() !== 1) begin bad++; $display("FAIL sdr4_ndone got=%0d exp=1", done_c.size()); end
    if (done_c.size() >= 1) begin
      total++; if (done_c[0] !== s + 25) begin bad++; $display("FAIL sdr4_tdone got=%0d exp=%0d", done_c[0], s + 25); end
    end
    total++; if (done_ee !== 1'b0) begin bad++; $display("FAIL sdr4_end_err got=%b exp=0", done_ee); end
  endtask

  task automatic test_sdr1_prbs();
    int a, s, nbad;
    logic [15:0] lfsr;
    logic [31:0] acc_w;
    logic [31:0] exp_w[$];
    logic b;
    clear_mon();
    lfsr = 16'hACE1; acc_w = '0; nbad = 0;
    arm(1'b0, 2'd0, 12'd512, 16'd0, a);
    start_bit(s);
    for (int i = 0; i < 4096; i++) begin
      b = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
      lfsr = {lfsr[14:0], b};
      acc_w = {acc_w[30:0], b};
      if (i % 32 == 31) exp_w.push_back(acc_w);
      beat({lfsr[7:1], b}, lfsr[15:8]);
    end
    crc_end(8'h01);
    total++; if (got_w.size() !== 128) begin bad++; $display("FAIL prbs_nwords got=%0d exp=128", got_w.size()); end
    for (int k = 0; k < 128 && k < got_w.size(); k++) begin
      total++;
      if (got_w[k] !== exp_w[k]) begin
        bad++; nbad++;
        if (nbad <= 4) $display("FAIL prbs_w%0d got=%h exp=%h", k, got_w[k], exp_w[k]);
      end
    end
    if (got_c.size() >= 128) begin
      total++; if (got_c[127] !== s + 4096) begin bad++; $display("FAIL prbs_tlast got=%0d exp=%0d", got_c[127], s + 4096); end
    end
    total++; if (done_c.size() !== 1) begin bad++; $display("FAIL prbs_ndone got=%0d exp=1", done_c.size()); end
    if (done_c.size() >= 1) begin
      total++; if (done_c[0] !== s + 4113) begin bad++; $display("FAIL prbs_tdone got=%0d exp=%0d", done_c[0], s + 4113); end
    end
    total++; if (done_ee !== 1'b0) begin bad++; $display("FAIL prbs_end_err got=%b exp=0", done_ee); end
  endtask

  task automatic test_end_err();
    int a, s;
    clear_mon();
    arm(1'b0, 2'd2, 12'd4, 16'd0, a);
    start_bit(s);
    beat(8'hDE, 8'h00); beat(8'hAD, 8'h00); beat(8'hBE, 8'h00); beat(8'hEF, 8'h00);
    crc_end(8'hFE);
    total++; if (got_w.size() !== 1) begin bad++; $display("FAIL ee_nwords got=%0d exp=1", got_w.size()); end
    if (got_w.size() >= 1) begin
      total++; if (got_w[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL ee_w0 got=%h exp=deadbeef", got_w[0]); end
    end
    total++; if (done_c.size() !== 1) begin bad++; $display("FAIL ee_ndone got=%0d exp=1", done_c.size()); end
    if (done_c.size() >= 1) begin
      total++; if (done_c[0] !== s + 21) begin bad++; $display("FAIL ee_tdone got=%0d exp=%0d", done_c[0], s + 21); end
    end
    total++; if (done_ee !== 1'b1) begin bad++; $display("FAIL ee_flag got=%b exp=1", done_ee); end
    // abort in IDLE leaves the held flag alone
    bus.abort = 1'b1; @(negedge clock); bus.abort = 1'b0; @(negedge clock);
    total++; if (bus.end_err !== 1'b1) begin bad++; $display("FAIL ee_held got=%b exp=1", bus.end_err); end
    arm(1'b0, 2'd2, 12'd4, 16'd0, a);
    total++; if (bus.end_err !== 1'b0) begin bad++; $display("FAIL ee_clear got=%b exp=0", bus.end_err); end
    bus.abort = 1'b1; @(negedge clock); bus.abort = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_timeout();
    int a;
    clear_mon();
    arm(1'b0, 2'd2, 12'd4, 16'd100, a);
    repeat (120) beat(8'hFF, 8'hFF);
    total++; if (done_c.size() !== 1) begin bad++; $display("FAIL to_ndone got=%0d exp=1", done_c.size()); end
    if (done_c.size() >= 1) begin
      total++; if (done_c[0] !== a + 100) begin bad++; $display("FAIL to_tdone got=%0d exp=%0d", done_c[0], a + 100); end
    end
    total++; if (done_te !== 1'b1) begin bad++; $display("FAIL to_flag got=%b exp=1", done_te); end
    total++; if (bus.to_err !== 1'b1) begin bad++; $display("FAIL to_held got=%b exp=1", bus.to_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL to_busy got=%b exp=0", bus.busy); end
    // timeout=0: wait forever
    arm(1'b0, 2'd2, 12'd4, 16'd0, a);
    total++; if (bus.to_err !== 1'b0) begin bad++; $display("FAIL to0_clear got=%b exp=0", bus.to_err); end
    repeat (300) beat(8'hFF, 8'hFF);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL to0_busy got=%b exp=1", bus.busy); end
    total++; if (done_c.size() !== 1) begin bad++; $display("FAIL to0_ndone got=%0d exp=1", done_c.size()); end
    bus.abort = 1'b1; @(negedge clock); bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL to0_abort_busy got=%b exp=0", bus.busy); end
    repeat (3) @(negedge clock);
    total++; if (done_c.size() !== 1) begin bad++; $display("FAIL to0_abort_done got=%0d exp=1", done_c.size()); end
  endtask

  task automatic test_abort();
    int a, s;
    clear_mon();
    arm(1'b0, 2'd2, 12'd8, 16'd0, a);
    start_bit(s);
    beat(8'h11, 8'h00); beat(8'h22, 8'h00); beat(8'h33, 8'h00);
    bus.abort = 1'b1; beat(8'h44, 8'h00); bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ab_busy got=%b exp=0", bus.busy); end
    // immediate re-arm receives a clean block
    arm(1'b0, 2'd2, 12'd8, 16'd0, a);
    start_bit(s);
    for (int i = 0; i < 8; i++) beat(8'h10 + 8'(i), 8'hFF);
    crc_end(8'hFF);
    total++; if (got_w.size() !== 2) begin bad++; $display("FAIL ab_nwords got=%0d exp=2", got_w.size()); end
    if (got_w.size() >= 2) begin
      total++; if (got_w[0] !== 32'h10111213) begin bad++; $display("FAIL ab_w0 got=%h exp=10111213", got_w[0]); end
      total++; if (got_w[1] !== 32'h14151617) begin bad++; $display("FAIL ab_w1 got=%h exp=14151617", got_w[1]); end
    end
    total++; if (done_c.size() !== 1) begin bad++; $display("FAIL ab_ndone got=%0d exp=1", done_c.size()); end
    if (done_c.size() >= 1) begin
      total++; if (done_c[0] !== s + 25) begin bad++; $display("FAIL ab_tdone got=%0d exp=%0d", done_c[0], s + 25); end
    end
    // abort and start together in IDLE: not armed
    bus.abort = 1'b1; bus.start = 1'b1; @(negedge clock); bus.abort = 1'b0; bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ab_start_busy got=%b exp=0", bus.busy); end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    bus.rx_q1 = 8'hFF; bus.rx_q2 = 8'hFF; bus.start = 1'b0; bus.abort = 1'b0;
    bus.ddr_en = 1'b0; bus.bus_width = 2'd0; bus.blk_len = 12'd4; bus.timeout = 16'd0;
    test_reset();
    test_ddr8();
    test_sdr4();
    test_sdr1_prbs();
    test_end_err();
    test_timeout();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
